// File: rtl/if_fetch_buf_if.sv
// Fetch-unit bundle: instruction memory port, redirect from execute and the decode-side
// head of the prefetch FIFO. The master modport is the fetch unit itself.
interface if_fetch_buf_if #(
  parameter int unsigned CPU_WIDTH = 32
);
  logic                 redirect_i;
  logic [CPU_WIDTH-1:0] redirect_pc_i;
  logic                 imem_req_o;
  logic [CPU_WIDTH-1:0] imem_addr_o;
  logic                 imem_gnt_i;
  logic                 imem_rvalid_i;
  logic [CPU_WIDTH-1:0] imem_rdata_i;
  logic                 inst_valid_o;
  logic [CPU_WIDTH-1:0] inst_o;
  logic [CPU_WIDTH-1:0] inst_pc_o;
  logic                 inst_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Instruction fetch unit with a small prefetch FIFO. Issues in-order reads at fetch_pc,
// tags returning data with resp_pc, and discards responses belonging to a flushed stream.
module if_fetch_buf #(
  parameter int unsigned          CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RST_PC    = '0,
  parameter int unsigned          DEPTH     = 4
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_buf_if.master bus
);

  localparam int unsigned   PtrW     = $clog2(DEPTH);
  localparam int unsigned   CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e               state_q;
  logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CPU_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]      out_q, out_d;
  logic [CntW-1:0]      stale_q, stale_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CPU_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [CPU_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic          redirect_act;
  logic [CntW:0] credit_used;
  logic          gnt_fire;
  logic          push;
  logic          drop;
  logic          pop;

  // A redirect in StIdle is ignored: nothing has been fetched yet.
  assign redirect_act = bus.redirect_i && (state_q != StIdle);
  // Outstanding reads reserve FIFO slots, so a push can never meet a full FIFO.
  assign credit_used  = {1'b0, out_q} + {1'b0, cnt_q};
  assign bus.imem_req_o = (state_q == StFetch) && !bus.redirect_i && (credit_used < DepthLim);
  assign bus.imem_addr_o = fetch_pc_q;
  assign gnt_fire = bus.imem_req_o && bus.imem_gnt_i;
  assign push     = bus.imem_rvalid_i && !redirect_act && (stale_q == '0);
  assign drop     = bus.imem_rvalid_i && !redirect_act && (stale_q != '0);
  assign pop      = bus.inst_ready_i && (cnt_q != '0) && !redirect_act;

  assign bus.inst_valid_o = (cnt_q != '0);
  assign bus.inst_o       = (cnt_q != '0) ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.inst_pc_o    = (cnt_q != '0) ? pc_mem_q[rd_ptr_q] : '0;

  // Next-state for PCs, read/stale counters and FIFO bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    stale_d    = stale_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_act) begin
      // Every old-stream read still pending after this cycle becomes stale.
      fetch_pc_d = bus.redirect_pc_i;
      resp_pc_d  = bus.redirect_pc_i;
      stale_d    = out_q + stale_q - CntW'(bus.imem_rvalid_i);
      out_d      = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + CPU_WIDTH'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + CPU_WIDTH'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (drop) stale_d  = stale_q - CntW'(1);
      out_d = out_q + CntW'(gnt_fire) - CntW'(push);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Fetch control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: if (redirect_act && (out_q != '0)) state_q <= StDrain;
        StDrain: if (stale_d == '0) state_q <= StFetch;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      out_q      <= '0;
      stale_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: queue-based reference model checked every cycle, a latency-driven
// memory responder, and directed scenarios with literal expectations.
module tb_if_fetch_buf;

  localparam int DEPTH = 4;
  localparam int MIdle = 0, MFetch = 1, MDrain = 2;

  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  if_fetch_buf_if #(.CPU_WIDTH(32)) bus ();

  if_fetch_buf #(.CPU_WIDTH(32), .RST_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;

  // Reference model state
  int          mst;
  logic [31:0] m_fetch, m_resp;
  int          m_out, m_stale;
  ent_t        m_fifo[$];

  mreq_t       mq[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_req(input bit redir);
    return (mst == MFetch) && !redir && (m_out + m_fifo.size() < DEPTH);
  endfunction

  task automatic model_reset();
    mst = MIdle; m_fetch = 32'h0; m_resp = 32'h0; m_out = 0; m_stale = 0;
    m_fifo.delete();
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc, input bit rdy,
                            input bit g, input bit rv);
    bit mreq;
    int nst;
    mreq = model_req(redir);
    if (redir && mst != MIdle) begin
      nst = m_out + m_stale - (rv ? 1 : 0);
      if (mst == MFetch) mst = (m_out > 0) ? MDrain : MFetch;
      else mst = (nst == 0) ? MFetch : MDrain;
      m_stale = nst; m_out = 0; m_fifo.delete();
      m_fetch = rpc; m_resp = rpc;
    end else begin
      if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (rv) begin
        if (m_stale > 0) m_stale--;
        else begin
          m_fifo.push_back('{inst: f(m_resp), pc: m_resp});
          m_resp += 32'd4;
          m_out--;
        end
      end
      if (mreq && g) begin m_fetch += 32'd4; m_out++; end
      if (mst == MIdle) mst = MFetch;
      else if (mst == MDrain && m_stale == 0) mst = MFetch;
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(bus.imem_req_o), 32'(model_req(bus.redirect_i)));
    chk("imem_addr", bus.imem_addr_o, m_fetch);
    chk("inst_valid", 32'(bus.inst_valid_o), 32'(m_fifo.size() > 0));
    chk("inst", bus.inst_o, (m_fifo.size() > 0) ? m_fifo[0].inst : 32'h0);
    chk("inst_pc", bus.inst_pc_o, (m_fifo.size() > 0) ? m_fifo[0].pc : 32'h0);
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy, input bit g);
    bit rv;
    bus.redirect_i = redir; bus.redirect_pc_i = rpc;
    bus.inst_ready_i = rdy; bus.imem_gnt_i = g;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i = rv ? f(mq[0].addr) : 32'h0;
    if (rv) void'(mq.pop_front());
    #1;
    compare();
    if (bus.inst_valid_o && rdy && !redir) pop_log.push_back(bus.inst_pc_o);
    if (bus.imem_req_o && g) begin
      mq.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
      gnt_log.push_back(bus.imem_addr_o);
    end
    model_step(redir, rpc, rdy, g, rv);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy, input bit g);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy, g);
  endtask

  // Asynchronous reset: outputs must drop without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req_o), 32'h0);
    chk("rst_valid", 32'(bus.inst_valid_o), 32'h0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst_inst_pc", bus.inst_pc_o, 32'h0);
    model_reset();
    mq.delete(); gnt_log.delete(); pop_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold decode off until the head is valid (bounded), then return whether it appeared.
  task automatic wait_head(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.inst_valid_o) begin got = 1'b1; break; end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    bit got;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.inst_ready_i = 1'b0;
    model_reset();
    @(negedge clk);

    // Streaming, 1-cycle memory, decode always ready
    do_reset();
    lat = 1;
    run(12, 1'b1, 1'b1);
    chk("stream_gnt0", gnt_log[0], 32'h0);
    chk("stream_gnt1", gnt_log[1], 32'h4);
    chk("stream_gnt2", gnt_log[2], 32'h8);
    chk("stream_pop0", pop_log[0], 32'h0);
    chk("stream_pop2", pop_log[2], 32'h8);
    chk("stream_rate", 32'(pop_log.size()), 32'd9);

    // Decode stalled: exactly DEPTH grants, then drain in order
    do_reset();
    run(12, 1'b0, 1'b1);
    chk("fill_grants", 32'(gnt_log.size()), 32'd4);
    chk("fill_req", 32'(bus.imem_req_o), 32'h0);
    chk("fill_addr", bus.imem_addr_o, 32'h10);
    chk("fill_head_pc", bus.inst_pc_o, 32'h0);
    chk("fill_head_inst", bus.inst_o, 32'h5A5A_0000);
    gnt_log.delete();
    run(10, 1'b1, 1'b1);
    chk("drain_pop3", pop_log[3], 32'hC);
    chk("resume_addr", gnt_log[0], 32'h10);

    // Redirect with reads in flight, 3-cycle memory
    do_reset();
    lat = 3;
    run(8, 1'b1, 1'b1);
    gnt_log.delete();
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    wait_head(got);
    chk("redir_got_head", 32'(got), 32'h1);
    chk("redir_head_pc", bus.inst_pc_o, 32'h100);
    chk("redir_head_inst", bus.inst_o, 32'h5A5A_0100);
    chk("redir_first_gnt", gnt_log[0], 32'h100);

    // Redirect coinciding with rvalid and pop, FIFO holding two entries
    do_reset();
    lat = 1;
    run(4, 1'b0, 1'b1);
    gnt_log.delete();
    cycle(1'b1, 32'h300, 1'b1, 1'b1);
    chk("coinc_empty", 32'(bus.inst_valid_o), 32'h0);
    wait_head(got);
    chk("coinc_head_pc", bus.inst_pc_o, 32'h300);
    chk("coinc_first_gnt", gnt_log[0], 32'h300);

    // Second redirect while draining stale reads
    do_reset();
    lat = 3;
    run(8, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    cycle(1'b1, 32'h200, 1'b1, 1'b1);
    wait_head(got);
    chk("redir2_got_head", 32'(got), 32'h1);
    chk("redir2_head_pc", bus.inst_pc_o, 32'h200);

    // Address wrap, then asynchronous reset mid-stream
    lat = 1;
    gnt_log.delete();
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 20 && gnt_log.size() < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_gnt0", gnt_log[0], 32'hFFFF_FFF8);
    chk("wrap_gnt1", gnt_log[1], 32'hFFFF_FFFC);
    chk("wrap_gnt2", gnt_log[2], 32'h0);
    run(3, 1'b1, 1'b1);
    do_reset();
    run(6, 1'b1, 1'b1);
    chk("post_rst_gnt0", gnt_log[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_buf.md
# if_fetch_buf

Instruction fetch unit that reads the instruction memory port on behalf of the core. It owns the fetch PC, issues in-order read requests, and tracks outstanding reads. Returned instructions are buffered with their PCs in a small prefetch FIFO that feeds decode. A redirect from execute flushes the FIFO and the in-flight stream; stale responses are discarded before fetching resumes at the new target.

## Interface
- CPU_WIDTH, 32, address/instruction width
- RST_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, FIFO entries and max outstanding reads; power of 2, ≥2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  CPU_WIDTH  new fetch target, valid with redirect_i
- imem_req_o  out  1  read request
- imem_addr_o  out  CPU_WIDTH  read address (current fetch PC)
- imem_gnt_i  in  1  request accepted this cycle (meaningful only with imem_req_o)
- imem_rvalid_i  in  1  read data valid; in order, ≥1 cycle after gnt
- imem_rdata_i  in  CPU_WIDTH  read data
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  CPU_WIDTH  FIFO head instruction
- inst_pc_o  out  CPU_WIDTH  PC of FIFO head
- inst_ready_i  in  1  decode accepts head this cycle

## Operation
- State: fetch_pc, resp_pc, outstanding count (0..DEPTH), stale count (0..DEPTH), FIFO (count 0..DEPTH, rd/wr pointers).
- FSM: S_IDLE → S_FETCH unconditionally, one cycle after reset release. In S_FETCH, redirect_i with outstanding>0 → S_DRAIN; with outstanding=0 stays S_FETCH. S_DRAIN → S_FETCH when stale count reaches 0 (including the cycle it decrements to 0).
- imem_req_o = (state==S_FETCH) && !redirect_i && (outstanding + fifo_count < DEPTH). Combinational; no request in S_IDLE or S_DRAIN.
- imem_addr_o = fetch_pc. On gnt: fetch_pc += 4, outstanding += 1.
- On rvalid, not redirect, stale=0: push {imem_rdata_i, resp_pc}; resp_pc += 4; outstanding -= 1.
- On rvalid, stale>0: drop; stale -= 1.
- Redirect (any state except S_IDLE): FIFO cleared; fetch_pc ← redirect_pc_i; resp_pc ← redirect_pc_i. Stale ← all old-stream reads still pending after this cycle: outstanding + stale − (rvalid this cycle ? 1 : 0). outstanding ← 0. A response arriving in the redirect cycle is dropped. Pop is ignored in the redirect cycle.
- Redirect in S_DRAIN: restarts target; stale counting continues across redirects.
- Credit rule guarantees push never meets full FIFO; push and pop in the same cycle are both honoured.
- Head outputs: inst_valid_o = fifo_count≠0. inst_o/inst_pc_o = head entry when valid, else 0.
- Address arithmetic wraps modulo 2^CPU_WIDTH (0xFFFF_FFFC + 4 → 0).

## Timing
- Reset (async): state S_IDLE, fetch_pc = resp_pc = RST_PC, all counts 0. Outputs: imem_req_o 0, imem_addr_o RST_PC, inst_valid_o 0, inst_o 0, inst_pc_o 0.
- First request is asserted in the 2nd rising edge after rst_n deasserts (S_IDLE occupies one cycle).
- imem_addr_o is stable while imem_req_o is high without gnt, except when redirect_i withdraws the request.
- Response-to-head latency: instruction is visible on inst_o the cycle after its rvalid.
- Back-to-back: with gnt every cycle and 1-cycle memory latency, one instruction per cycle sustained.
- Redirect-to-request: 1 cycle after redirect if no outstanding reads; otherwise 1 cycle after the last stale rvalid.
- rst_n mid-operation: all state returns to reset values immediately; later rvalids are the memory's responsibility and are not tracked.

## Test plan
- Reset release, gnt=1, 1-cycle rvalid returning addr as data, ready=1 → imem_addr 0,4,8,…; inst_pc_o/inst_o 0,4,8,… one per cycle after fill.
- ready=0 held, DEPTH=4 → exactly 4 grants, req drops, FIFO holds PCs 0x0..0xC; ready=1 → drains in order, fetching resumes at 0x10.
- Redirect to 0x100 with 3 reads outstanding (latency 3) → 3 rvalids dropped, no req during drain, first pushed inst_pc_o=0x100.
- Redirect same cycle as rvalid and pop, FIFO=2 → FIFO empty next cycle, response dropped, fetch at redirect_pc.
- Second redirect (0x200) during S_DRAIN → all stale dropped, head PC 0x200, never 0x100.
- fetch_pc = 0xFFFF_FFF8 via redirect → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; async reset mid-stream → req 0, inst_valid 0, addr RST_PC same cycle.
